mem_128x4_ctrl: RTL and testbench

Requester-side controller that drives the R0/W0 ports of a 128x4 bit-masked memory with 1-cycle registered read. Clears the whole array after reset or on request. Accepts read and masked-write commands over a valid/ready port, and returns read data over a 2-entry buffered response port with backpressure. Sits between a core-side client and the memory macro. The memory's R0_clk and W0_clk are tied to `clock` at the parent.

---
 rtl/mem_128x4_ctrl_pkg.sv | 16 +
 rtl/mem_128x4_ctrl_resp_queue_2.sv | 61 ++++++
 rtl/mem_128x4_ctrl.sv | 158 +++++++++++++++
 tb/tb_mem_128x4_ctrl.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_128x4_ctrl_pkg.sv
// Shared constants and types for the 128x4 memory requester controller.
//   ADDR_W / DATA_W : word address width and data/mask width
//   DEPTH           : number of words swept by the clear engine
//   state_t         : controller phase (array clear sweep or command service)
package mem_128x4_ctrl_pkg;

    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DATA_W = 4;
    localparam int unsigned DEPTH  = 128;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/mem_128x4_ctrl_resp_queue_2.sv
// Two-entry response FIFO whose head entry is a register, so pop_data and
// !empty come straight from flops.
//   clock, reset_n : clock and asynchronous active-low reset
//   push/push_data : write one entry (ignored when full)
//   pop            : drop the head entry (ignored when empty)
//   pop_data       : head entry data
//   full / empty   : occupancy flags
module resp_queue_2
    import mem_128x4_ctrl_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] head_data;
    logic [DATA_W-1:0] tail_data;
    logic              head_valid;
    logic              tail_valid;

    // Head/tail shift register; the tail refills the head on pop.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_data  <= '0;
            tail_data  <= '0;
            head_valid <= 1'b0;
            tail_valid <= 1'b0;
        end else if (pop && head_valid) begin
            if (tail_valid) begin
                head_data <= tail_data;
                if (push) begin
                    tail_data <= push_data;
                end else begin
                    tail_valid <= 1'b0;
                end
            end else if (push) begin
                head_data <= push_data;
            end else begin
                head_valid <= 1'b0;
            end
        end else if (push) begin
            if (!head_valid) begin
                head_data  <= push_data;
                head_valid <= 1'b1;
            end else if (!tail_valid) begin
                tail_data  <= push_data;
                tail_valid <= 1'b1;
            end
        end
    end

    assign pop_data = head_data;
    assign full     = tail_valid;
    assign empty    = !head_valid;

endmodule

// File: rtl/mem_128x4_ctrl.sv
// Requester-side controller for a 128x4 bit-masked memory with a 1-cycle
// registered read port. Zeroes the array after reset or on clear, then serves
// read / masked-write commands and returns read data in order through a
// 2-entry response queue.
//   clock, reset_n          : clock, asynchronous active-low reset
//   clear                   : request a re-zero of the array
//   init_done               : array zeroed, commands may be accepted
//   req_*                   : command port (valid/ready)
//   resp_*                  : read response port (valid/ready)
//   mem_R0_* / mem_W0_*     : memory macro read and write ports
module mem_128x4_ctrl
    import mem_128x4_ctrl_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              clear,
    output logic              init_done,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    input  logic [DATA_W-1:0] req_mask,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic [ADDR_W-1:0] mem_R0_addr,
    output logic              mem_R0_en,
    input  logic [DATA_W-1:0] mem_R0_data,
    output logic [ADDR_W-1:0] mem_W0_addr,
    output logic              mem_W0_en,
    output logic [DATA_W-1:0] mem_W0_data,
    output logic [DATA_W-1:0] mem_W0_mask
);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] sweep_cnt;
    logic              sweep_armed;
    logic              in_flight;
    logic              clear_pending;

    logic              accept;
    logic              rd_accept;
    logic              wr_accept;
    logic              sweep_last;
    logic              go_init;
    logic              q_pop;
    logic              q_full;
    logic              q_empty;
    logic [1:0]        q_count;
    logic [1:0]        outstanding;

    // Sweep is held off until the first edge out of reset, so the first
    // zeroing write lands one cycle later and init takes exactly DEPTH cycles.
    assign sweep_last  = sweep_armed && (sweep_cnt == ADDR_W'(DEPTH - 1));
    // A clear is only taken once no read is waiting on mem_R0_data.
    assign go_init     = (clear || clear_pending) && !in_flight;

    assign resp_valid  = !q_empty;
    assign q_pop       = resp_valid && resp_ready;
    assign q_count     = q_full ? 2'd2 : (q_empty ? 2'd0 : 2'd1);
    assign outstanding = q_count + {1'b0, in_flight};

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_INIT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            ST_INIT: if (sweep_last) state_next = ST_RUN;
            ST_RUN:  if (go_init)    state_next = ST_INIT;
        endcase
    end

    // Outputs: handshake and memory port drive.
    always_comb begin
        init_done   = 1'b0;
        req_ready   = 1'b0;
        mem_R0_en   = 1'b0;
        mem_R0_addr = '0;
        mem_W0_en   = 1'b0;
        mem_W0_addr = '0;
        mem_W0_data = '0;
        mem_W0_mask = '0;

        if (state == ST_RUN) begin
            init_done = 1'b1;
            // resp_ready -> req_ready is combinational: a pop frees a slot now.
            req_ready = !clear && !clear_pending && ((outstanding < 2'd2) || q_pop);
        end

        accept    = req_valid && req_ready;
        rd_accept = accept && !req_write;
        wr_accept = accept && req_write;

        if (state == ST_INIT && sweep_armed) begin
            mem_W0_en   = 1'b1;
            mem_W0_addr = sweep_cnt;
            mem_W0_mask = '1;
        end else if (wr_accept) begin
            mem_W0_en   = 1'b1;
            mem_W0_addr = req_addr;
            mem_W0_data = req_data;
            mem_W0_mask = req_mask;
        end

        if (rd_accept) begin
            mem_R0_en   = 1'b1;
            mem_R0_addr = req_addr;
        end
    end

    // Sweep counter, in-flight read tracking and deferred clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sweep_cnt     <= '0;
            sweep_armed   <= 1'b0;
            in_flight     <= 1'b0;
            clear_pending <= 1'b0;
        end else begin
            sweep_armed <= 1'b1;
            in_flight   <= rd_accept;

            if (state == ST_INIT) begin
                sweep_cnt <= sweep_armed ? sweep_cnt + ADDR_W'(1) : '0;
            end else if (go_init) begin
                sweep_cnt <= '0;
            end

            if (state == ST_RUN && go_init) begin
                clear_pending <= 1'b0;
            end else if (state == ST_RUN && clear && in_flight) begin
                clear_pending <= 1'b1;
            end
        end
    end

    // Read data is captured the cycle after the read was issued.
    resp_queue_2 u_resp_queue (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (in_flight),
        .push_data (mem_R0_data),
        .pop       (q_pop),
        .pop_data  (resp_data),
        .full      (q_full),
        .empty     (q_empty)
    );

endmodule

// File: tb/tb_mem_128x4_ctrl.sv
// Self-checking bench for mem_128x4_ctrl: behavioural memory macro plus an
// array/queue reference model of what each read must return.
module tb_mem_128x4_ctrl;
    import mem_128x4_ctrl_pkg::*;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              clear;
    logic              init_done;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;
    logic [DATA_W-1:0] req_mask;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_data;
    logic [ADDR_W-1:0] mem_R0_addr;
    logic              mem_R0_en;
    logic [DATA_W-1:0] mem_R0_data;
    logic [ADDR_W-1:0] mem_W0_addr;
    logic              mem_W0_en;
    logic [DATA_W-1:0] mem_W0_data;
    logic [DATA_W-1:0] mem_W0_mask;

    int n_tests = 0;
    int n_fail  = 0;

    mem_128x4_ctrl dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .clear       (clear),
        .init_done   (init_done),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .req_mask    (req_mask),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_data   (resp_data),
        .mem_R0_addr (mem_R0_addr),
        .mem_R0_en   (mem_R0_en),
        .mem_R0_data (mem_R0_data),
        .mem_W0_addr (mem_W0_addr),
        .mem_W0_en   (mem_W0_en),
        .mem_W0_data (mem_W0_data),
        .mem_W0_mask (mem_W0_mask)
    );

    always #5 clock = ~clock;

    // Memory macro: masked write, registered read of the pre-write contents.
    logic [DATA_W-1:0] macro_mem [DEPTH];
    always @(posedge clock) begin
        if (mem_W0_en)
            macro_mem[mem_W0_addr] <= (macro_mem[mem_W0_addr] & ~mem_W0_mask) | (mem_W0_data & mem_W0_mask);
        if (mem_R0_en) mem_R0_data <= macro_mem[mem_R0_addr];
        else           mem_R0_data <= DATA_W'($urandom);
    end

    // Reference model: architectural array contents and pending read results.
    logic [DATA_W-1:0] ref_mem [DEPTH];
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] got_q[$];
    logic [DATA_W-1:0] want_q[$];
    int                spurious = 0;

    logic              o_ready, o_done, o_rvalid, o_r_en, o_w_en, acc, fire;
    logic [DATA_W-1:0] o_rdata, o_w_data, o_w_mask;
    logic [ADDR_W-1:0] o_r_addr, o_w_addr;

    task automatic drive(input logic v, input logic w, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] m);
        req_valid = v; req_write = w; req_addr = a; req_data = d; req_mask = m;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic model_zero();
        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = '0;
    endtask

    // One clock: sample at negedge, advance the model, return at posedge+1.
    task automatic settle();
        @(negedge clock);
        o_ready = req_ready;  o_done = init_done;  o_rvalid = resp_valid; o_rdata = resp_data;
        o_r_en = mem_R0_en;   o_r_addr = mem_R0_addr;
        o_w_en = mem_W0_en;   o_w_addr = mem_W0_addr; o_w_data = mem_W0_data; o_w_mask = mem_W0_mask;
        acc  = req_valid && req_ready;
        fire = resp_valid && resp_ready;
        if (fire) begin
            got_q.push_back(resp_data);
            if (exp_q.size() > 0) want_q.push_back(exp_q.pop_front());
            else spurious++;
        end
        if (acc) begin
            if (req_write) ref_mem[req_addr] = (ref_mem[req_addr] & ~req_mask) | (req_data & req_mask);
            else           exp_q.push_back(ref_mem[req_addr]);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                         input logic [DATA_W-1:0] m, output bit ok);
        ok = 1'b0;
        drive(1'b1, w, a, d, m);
        for (int i = 0; i < 50 && !ok; i++) begin
            settle();
            ok = acc;
        end
        idle();
    endtask

    task automatic drain(output bit timed_out);
        int guard = 0;
        resp_ready = 1'b1;
        while (exp_q.size() > 0 && guard < 400) begin
            settle();
            guard++;
        end
        settle();
        timed_out = (exp_q.size() > 0);
    endtask

    task automatic test_reset();
        bit ok, to;
        int bad = 0;
        reset_n = 1'b0; clear = 1'b0; resp_ready = 1'b0; idle();
        repeat (3) settle();
        n_tests++;
        if ({o_ready, o_done, o_rvalid, o_rdata, o_r_en, o_r_addr, o_w_en, o_w_addr, o_w_data, o_w_mask} !== 31'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ready=%b done=%b rvalid=%b rdata=%h r_en=%b w_en=%b w_addr=%h, want all 0",
                     o_ready, o_done, o_rvalid, o_rdata, o_r_en, o_w_en, o_w_addr);
        end
        exp_q.delete(); model_zero();
        reset_n = 1'b1;
        settle();
        n_tests++;
        if (o_w_en !== 1'b0) begin n_fail++; $display("FAIL pre_sweep_idle: w_en=%b want 0", o_w_en); end
        for (int k = 0; k < int'(DEPTH); k++) begin
            settle();
            n_tests++;
            if (o_w_en !== 1'b1 || o_w_addr !== ADDR_W'(k) || o_w_data !== 4'h0 || o_w_mask !== 4'hF || o_done !== 1'b0) begin
                n_fail++; bad++;
                if (bad < 5) $display("FAIL init_sweep[%0d]: en=%b addr=%0d data=%h mask=%h done=%b, want 1 %0d 0 f 0",
                                      k, o_w_en, o_w_addr, o_w_data, o_w_mask, o_done, k);
            end
        end
        settle();
        n_tests++;
        if ({o_done, o_ready, o_w_en} !== 3'b110) begin
            n_fail++; $display("FAIL init_done_rise: done=%b ready=%b w_en=%b, want 1 1 0", o_done, o_ready, o_w_en);
        end
        got_q.delete(); want_q.delete();
        issue(1'b0, 7'h55, 4'h0, 4'h0, ok);
        drain(to);
        n_tests++;
        if (!ok || to || got_q.size() != 1 || got_q[0] !== 4'h0) begin
            n_fail++; $display("FAIL read_after_init: accepted=%b n=%0d data=%h, want 1 1 0", ok, got_q.size(), (got_q.size() > 0) ? got_q[0] : 4'h0);
        end
    endtask

    task automatic test_masked_write();
        bit ok;
        issue(1'b1, 7'd3, 4'hF, 4'hF, ok);
        n_tests++;
        if (!ok || {o_w_en, o_w_addr, o_w_data, o_w_mask, o_r_en} !== {1'b1, 7'd3, 4'hF, 4'hF, 1'b0}) begin
            n_fail++; $display("FAIL write_port_drive: acc=%b en=%b addr=%0d data=%h mask=%h r_en=%b, want 1 1 3 f f 0",
                               ok, o_w_en, o_w_addr, o_w_data, o_w_mask, o_r_en);
        end
        issue(1'b1, 7'd3, 4'h0, 4'b0101, ok);
        resp_ready = 1'b1;
        got_q.delete(); want_q.delete();
        drive(1'b1, 1'b0, 7'd3, '0, '0);
        settle();
        idle();
        n_tests++;
        if ({acc, o_r_en, o_r_addr, o_w_en} !== {1'b1, 1'b1, 7'd3, 1'b0}) begin
            n_fail++; $display("FAIL read_port_drive: acc=%b r_en=%b addr=%0d w_en=%b, want 1 1 3 0", acc, o_r_en, o_r_addr, o_w_en);
        end
        settle();
        n_tests++;
        if (o_rvalid !== 1'b0) begin n_fail++; $display("FAIL read_latency_n1: rvalid=%b want 0", o_rvalid); end
        settle();
        n_tests++;
        if (o_rvalid !== 1'b1 || o_rdata !== 4'hA) begin
            n_fail++; $display("FAIL masked_write_read: rvalid=%b data=%h, want 1 a", o_rvalid, o_rdata);
        end
    endtask

    task automatic test_read_then_write();
        bit ok, to, a1, a2, a3;
        issue(1'b1, 7'd9, 4'h6, 4'hF, ok);
        resp_ready = 1'b1;
        got_q.delete(); want_q.delete();
        drive(1'b1, 1'b0, 7'd9, '0, '0);   settle(); a1 = acc;
        drive(1'b1, 1'b1, 7'd9, 4'h1, 4'hF); settle(); a2 = acc;
        drive(1'b1, 1'b0, 7'd9, '0, '0);   settle(); a3 = acc;
        idle();
        drain(to);
        n_tests++;
        if ({a1, a2, a3} !== 3'b111 || to) begin
            n_fail++; $display("FAIL rw_accepts: got %b%b%b timeout=%b, want 111 0", a1, a2, a3, to);
        end
        n_tests++;
        if (got_q.size() != 2 || got_q[0] !== 4'h6 || got_q[1] !== 4'h1) begin
            n_fail++; $display("FAIL read_then_write_order: n=%0d, want 2 responses 6 then 1", got_q.size());
        end
    endtask

    task automatic test_backpressure();
        bit ok, to;
        int n_acc = 0;
        logic [15:0] seq;
        for (int i = 0; i < 4; i++) issue(1'b1, ADDR_W'(i), DATA_W'(i + 1), 4'hF, ok);
        resp_ready = 1'b0;
        got_q.delete(); want_q.delete();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0, ADDR_W'(n_acc), '0, '0);
            settle();
            if (acc) n_acc++;
        end
        n_tests++;
        if (n_acc != 2 || o_ready !== 1'b0 || o_rvalid !== 1'b1) begin
            n_fail++; $display("FAIL backpressure_limit: accepted=%0d ready=%b rvalid=%b, want 2 0 1", n_acc, o_ready, o_rvalid);
        end
        resp_ready = 1'b1;
        for (int g = 0; g < 50 && n_acc < 4; g++) begin
            drive(1'b1, 1'b0, ADDR_W'(n_acc), '0, '0);
            settle();
            if (acc) n_acc++;
        end
        idle();
        drain(to);
        seq = 16'h0;
        if (got_q.size() == 4) seq = {got_q[0], got_q[1], got_q[2], got_q[3]};
        n_tests++;
        if (to || got_q.size() != 4 || seq !== 16'h1234) begin
            n_fail++; $display("FAIL backpressure_order: n=%0d seq=%h timeout=%b, want 4 1234 0", got_q.size(), seq, to);
        end
    endtask

    task automatic test_random();
        bit to, w;
        int bad = 0;
        got_q.delete(); want_q.delete(); spurious = 0;
        for (int c = 0; c < 600; c++) begin
            resp_ready = ($urandom_range(0, 3) != 0);
            w = 1'($urandom);
            drive(($urandom_range(0, 3) != 0), w, ADDR_W'($urandom_range(0, 15)), DATA_W'($urandom), DATA_W'($urandom));
            settle();
            n_tests++;
            if (o_r_en !== (acc && !w) || o_w_en !== (acc && w)) begin
                n_fail++; bad++;
                if (bad < 5) $display("FAIL random_enables[%0d]: r_en=%b w_en=%b, want %b %b", c, o_r_en, o_w_en, acc && !w, acc && w);
            end
        end
        idle();
        drain(to);
        n_tests++;
        if (to || spurious != 0 || got_q.size() != want_q.size()) begin
            n_fail++; $display("FAIL random_count: got=%0d want=%0d spurious=%0d timeout=%b", got_q.size(), want_q.size(), spurious, to);
        end
        for (int i = 0; i < got_q.size() && i < want_q.size(); i++) begin
            n_tests++;
            if (got_q[i] !== want_q[i]) begin
                n_fail++; $display("FAIL random_data[%0d]: got %h want %h", i, got_q[i], want_q[i]);
            end
        end
    endtask

    task automatic test_clear();
        bit ok, to, first_low;
        int low = 0, bad = 0, idx = 0, nz = 0;
        // Idle clear: init_done low for exactly DEPTH cycles.
        clear = 1'b1; settle(); clear = 1'b0; model_zero();
        for (int g = 0; g < 300; g++) begin
            settle();
            if (o_done) break;
            low++;
        end
        n_tests++;
        if (low != int'(DEPTH)) begin n_fail++; $display("FAIL clear_idle_len: low cycles=%0d want %0d", low, DEPTH); end
        // Clear while a read is in flight.
        issue(1'b1, 7'd20, 4'h7, 4'hF, ok);
        for (int i = 40; i < 48; i++) issue(1'b1, ADDR_W'(i), 4'hC, 4'hF, ok);
        resp_ready = 1'b1;
        got_q.delete(); want_q.delete();
        drive(1'b1, 1'b0, 7'd20, '0, '0); settle(); idle();
        clear = 1'b1; settle(); clear = 1'b0;
        n_tests++;
        if (o_ready !== 1'b0) begin n_fail++; $display("FAIL clear_blocks_ready: ready=%b want 0", o_ready); end
        model_zero();
        settle();
        n_tests++;
        if (o_rvalid !== 1'b1 || o_rdata !== 4'h7 || o_done !== 1'b1) begin
            n_fail++; $display("FAIL clear_inflight_resp: rvalid=%b data=%h done=%b, want 1 7 1", o_rvalid, o_rdata, o_done);
        end
        settle();
        first_low = !o_done;
        for (int g = 0; g < 300; g++) begin
            if (o_done) break;
            if (o_w_en !== 1'b1 || o_w_addr !== ADDR_W'(idx)) bad++;
            idx++;
            settle();
        end
        n_tests++;
        if (!first_low || idx != int'(DEPTH) || bad != 0) begin
            n_fail++; $display("FAIL clear_inflight_sweep: starts_next=%b low=%0d bad=%0d, want 1 %0d 0", first_low, idx, bad, DEPTH);
        end
        got_q.delete(); want_q.delete();
        for (int a = 0; a < int'(DEPTH); a++) issue(1'b0, ADDR_W'(a), '0, '0, ok);
        drain(to);
        foreach (got_q[i]) if (got_q[i] !== 4'h0) nz++;
        n_tests++;
        if (to || got_q.size() != int'(DEPTH) || nz != 0) begin
            n_fail++; $display("FAIL clear_all_zero: n=%0d nonzero=%0d timeout=%b, want %0d 0 0", got_q.size(), nz, to, DEPTH);
        end
    endtask

    task automatic test_reset_during_init();
        bit hit = 1'b0;
        int low = 0;
        resp_ready = 1'b0;
        drive(1'b1, 1'b0, 7'd1, '0, '0); settle();
        drive(1'b1, 1'b0, 7'd2, '0, '0); settle();
        idle();
        clear = 1'b1; settle(); clear = 1'b0;
        for (int g = 0; g < 300 && !hit; g++) begin
            settle();
            hit = !o_done && o_w_en && (o_w_addr == 7'd59);
        end
        n_tests++;
        if (!hit || o_rvalid !== 1'b1) begin
            n_fail++; $display("FAIL reach_count_60: reached=%b rvalid=%b, want 1 1", hit, o_rvalid);
        end
        reset_n = 1'b0;
        settle();
        n_tests++;
        if ({o_ready, o_done, o_rvalid, o_rdata, o_r_en, o_r_addr, o_w_en, o_w_addr, o_w_data, o_w_mask} !== 31'd0) begin
            n_fail++; $display("FAIL reset_mid_init: ready=%b done=%b rvalid=%b rdata=%h w_en=%b w_addr=%0d, want all 0",
                               o_ready, o_done, o_rvalid, o_rdata, o_w_en, o_w_addr);
        end
        exp_q.delete(); model_zero();
        reset_n = 1'b1;
        settle();
        settle();
        n_tests++;
        if (o_w_en !== 1'b1 || o_w_addr !== 7'd0) begin
            n_fail++; $display("FAIL sweep_restart: en=%b addr=%0d, want 1 0", o_w_en, o_w_addr);
        end
        low = 1;
        for (int g = 0; g < 300; g++) begin
            settle();
            if (o_done) break;
            low++;
        end
        n_tests++;
        if (low != int'(DEPTH) || o_rvalid !== 1'b0) begin
            n_fail++; $display("FAIL restart_init_len: low=%0d rvalid=%b, want %0d 0", low, o_rvalid, DEPTH);
        end
    endtask

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) macro_mem[i] <= DATA_W'($urandom) | 4'h1;
        test_reset();
        test_masked_write();
        test_read_then_write();
        test_backpressure();
        test_random();
        test_clear();
        test_reset_during_init();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
